// File: rtl/cache_req_arbiter_if.sv
// Request/response bundle shared by requester ports and the cache port.
// Signals: req_valid/rw/size/addr/wdata, req_ready, resp_valid/hit/rdata.
// master: drives req_*, samples req_ready and resp_*.
// slave:  samples req_*, drives req_ready and resp_*.
interface cache_req_arbiter_if;
  logic        req_valid;
  logic        req_rw;
  logic [1:0]  req_size;
  logic [19:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_hit;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_rw, req_size,
    output req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_hit, resp_rdata
  );

  modport slave (
    input  req_valid, req_rw, req_size,
    input  req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_hit, resp_rdata
  );
endinterface

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter: fetch (p0) and data (p1) share one blocking cache port.
// Ports: clk_50, rst_n; p0/p1 slave bundles; c master bundle to the cache;
// busy (ISSUE/WAIT), owner (last grant), timeout_err (sticky watchdog flag).
module cache_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                       clk_50,
  input  logic                       rst_n,
  cache_req_arbiter_if.slave         p0,
  cache_req_arbiter_if.slave         p1,
  cache_req_arbiter_if.master        c,
  output logic                       busy,
  output logic                       owner,
  output logic                       timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  logic        own_q, own_d;
  logic        terr_q, terr_d;
  logic [15:0] wd_q, wd_d;
  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic [19:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        v0_q, v0_d, v1_q, v1_d;
  logic        h0_q, h0_d, h1_q, h1_d;
  logic [31:0] d0_q, d0_d, d1_q, d1_d;

  logic        st_idle, st_issue, st_wait;
  logic        grant, accept;
  logic        resp_in, wd_fire;
  logic        rhit;
  logic [31:0] rdata;

  assign st_idle  = (state_q == IDLE);
  assign st_issue = (state_q == ISSUE);
  assign st_wait  = (state_q == WAIT);

  // p1 wins when alone, or when both request and it is p1's turn.
  assign grant  = p1.req_valid & (~p0.req_valid | rr_q);
  assign accept = st_idle & c.req_ready &
                  (grant ? p1.req_valid : p0.req_valid);

  // Responses only count while a request is outstanding.
  assign resp_in = (st_issue | st_wait) & c.resp_valid;
  // A real response in the expiry cycle takes priority.
  assign wd_fire = st_wait & ~c.resp_valid & (wd_q == WD_LAST);

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = resp_in ? IDLE : WAIT;
      WAIT:    if (resp_in || wd_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    c.req_valid  = 1'b0;
    p0.req_ready = 1'b0;
    p1.req_ready = 1'b0;
    unique case (1'b1)
      st_idle: begin
        p0.req_ready = c.req_ready & ~grant;
        p1.req_ready = c.req_ready & grant;
      end
      st_issue: begin
        busy        = 1'b1;
        c.req_valid = 1'b1;
      end
      st_wait: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_comb begin
    rr_d    = rr_q;
    own_d   = own_q;
    terr_d  = terr_q;
    wd_d    = wd_q;
    rw_d    = rw_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    v0_d    = 1'b0;
    v1_d    = 1'b0;
    h0_d    = h0_q;
    h1_d    = h1_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    rhit    = resp_in ? c.resp_hit : 1'b0;
    rdata   = resp_in ? c.resp_rdata : ERR_DATA;

    if (accept) begin
      rr_d    = ~grant;
      own_d   = grant;
      rw_d    = grant ? p1.req_rw    : p0.req_rw;
      size_d  = grant ? p1.req_size  : p0.req_size;
      addr_d  = grant ? p1.req_addr  : p0.req_addr;
      wdata_d = grant ? p1.req_wdata : p0.req_wdata;
    end

    if (st_issue) begin
      wd_d = '0;
    end else if (st_wait && wd_q != WD_LAST) begin
      wd_d = wd_q + 16'd1;
    end

    if (resp_in || wd_fire) begin
      if (own_q) begin
        v1_d = 1'b1;
        h1_d = rhit;
        d1_d = rdata;
      end else begin
        v0_d = 1'b1;
        h0_d = rhit;
        d0_d = rdata;
      end
    end

    if (wd_fire) terr_d = 1'b1;
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= 1'b0;
      own_q   <= 1'b0;
      terr_q  <= 1'b0;
      wd_q    <= '0;
      rw_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      h0_q    <= 1'b0;
      h1_q    <= 1'b0;
      d0_q    <= '0;
      d1_q    <= '0;
    end else begin
      rr_q    <= rr_d;
      own_q   <= own_d;
      terr_q  <= terr_d;
      wd_q    <= wd_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
    end
  end

  assign c.req_rw      = rw_q;
  assign c.req_size    = size_q;
  assign c.req_addr    = addr_q;
  assign c.req_wdata   = wdata_q;
  assign p0.resp_valid = v0_q;
  assign p0.resp_hit   = h0_q;
  assign p0.resp_rdata = d0_q;
  assign p1.resp_valid = v1_q;
  assign p1.resp_hit   = h1_q;
  assign p1.resp_rdata = d1_q;
  assign owner         = own_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter with a scoreboard of expected
// cache requests and port responses, plus a small cache responder model.
module tb_cache_req_arbiter;

  localparam int TO = 64;

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic [19:0] addr;
    logic [31:0] wdata;
  } creq_t;

  typedef struct {
    logic        port;
    logic        hit;
    logic [31:0] rdata;
  } resp_t;

  logic clk_50 = 1'b0;
  logic rst_n;
  logic busy, owner, timeout_err;

  cache_req_arbiter_if p0();
  cache_req_arbiter_if p1();
  cache_req_arbiter_if c();

  cache_req_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk_50(clk_50),
    .rst_n(rst_n),
    .p0(p0),
    .p1(p1),
    .c(c),
    .busy(busy),
    .owner(owner),
    .timeout_err(timeout_err)
  );

  always #10 clk_50 = ~clk_50;

  int    n_checks = 0;
  int    n_errs = 0;
  int    cyc = 0;
  int    creq_cyc = 0;
  int    resp_cyc = 0;
  int    ta, tb_acc, tr;
  int    cdelay;
  bit    cmute;
  logic  fix_en, fix_hit;
  logic  [31:0] fix_rdata;
  logic  [19:0] ra;
  creq_t exp_creq[$];
  resp_t exp_resp[$];
  creq_t me;
  resp_t mr;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [19:0] a);
    return fix_en ? fix_rdata : {12'hC0D, a};
  endfunction

  function automatic logic model_hit(input logic [19:0] a);
    return fix_en ? fix_hit : ~a[2];
  endfunction

  task automatic expect_txn(input logic port, input logic rw,
                            input logic [1:0] size,
                            input logic [19:0] addr,
                            input logic [31:0] wdata,
                            input logic to);
    exp_creq.push_back(creq_t'{rw, size, addr, wdata});
    exp_resp.push_back(resp_t'{port,
      to ? 1'b0 : model_hit(addr),
      to ? 32'hDEADBEEF : model_rdata(addr)});
  endtask

  task automatic drive_req(input logic port, input logic rw,
                           input logic [1:0] size,
                           input logic [19:0] addr,
                           input logic [31:0] wdata);
    if (port) begin
      p1.req_valid = 1'b1; p1.req_rw = rw; p1.req_size = size;
      p1.req_addr = addr; p1.req_wdata = wdata;
    end else begin
      p0.req_valid = 1'b1; p0.req_rw = rw; p0.req_size = size;
      p0.req_addr = addr; p0.req_wdata = wdata;
    end
  endtask

  task automatic drop_req(input logic port);
    if (port) p1.req_valid = 1'b0;
    else p0.req_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_50);
    #2;
  endtask

  task automatic wait_acc(input logic port, input string tag,
                          output int t);
    logic got;
    got = 1'b0;
    t = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk_50);
      #1;
      if (port ? p1.req_ready : p0.req_ready) begin
        got = 1'b1;
        t = cyc;
      end
    end
    check({"acc_", tag}, {31'd0, got}, 32'd1);
    step();
  endtask

  task automatic wait_drain(input string tag, input int bound);
    for (int i = 0; i < bound &&
         (exp_resp.size() != 0 || exp_creq.size() != 0); i++) begin
      @(negedge clk_50);
      #1;
    end
    check({"drain_", tag}, exp_resp.size() + exp_creq.size(), 0);
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk_50);
      cyc++;
      if (rst_n) begin
        check("ready_excl", {31'd0, p0.req_ready & p1.req_ready}, 0);
        check("ready_busy",
              {31'd0, (p0.req_ready | p1.req_ready) & busy}, 0);
        if (c.req_valid) begin
          creq_cyc = cyc;
          if (exp_creq.size() == 0) begin
            check("creq_unexp", {31'd0, c.req_valid}, 0);
          end else begin
            me = exp_creq.pop_front();
            check("creq_addr", {12'd0, c.req_addr}, {12'd0, me.addr});
            check("creq_rw", {31'd0, c.req_rw}, {31'd0, me.rw});
            check("creq_size", {30'd0, c.req_size}, {30'd0, me.size});
            check("creq_wdata", c.req_wdata, me.wdata);
          end
        end
        if (p0.resp_valid || p1.resp_valid) begin
          resp_cyc = cyc;
          check("resp_both", {31'd0, p0.resp_valid & p1.resp_valid}, 0);
          if (exp_resp.size() == 0) begin
            check("resp_unexp",
                  {31'd0, p0.resp_valid | p1.resp_valid}, 0);
          end else begin
            mr = exp_resp.pop_front();
            check("resp_port", {31'd0, p1.resp_valid}, {31'd0, mr.port});
            check("resp_hit",
                  {31'd0, mr.port ? p1.resp_hit : p0.resp_hit},
                  {31'd0, mr.hit});
            check("resp_rdata",
                  mr.port ? p1.resp_rdata : p0.resp_rdata, mr.rdata);
          end
        end
      end
    end
  endtask

  task automatic cache_loop();
    forever begin
      @(negedge clk_50);
      if (rst_n && c.req_valid && !cmute) begin
        ra = c.req_addr;
        repeat (cdelay) @(posedge clk_50);
        #2;
        if (!cmute) begin
          c.resp_valid = 1'b1;
          c.resp_hit = model_hit(ra);
          c.resp_rdata = model_rdata(ra);
          step();
          c.resp_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    p0.req_valid = 0; p0.req_rw = 0; p0.req_size = 0;
    p0.req_addr = 0; p0.req_wdata = 0;
    p1.req_valid = 0; p1.req_rw = 0; p1.req_size = 0;
    p1.req_addr = 0; p1.req_wdata = 0;
    c.req_ready = 1'b1;
    c.resp_valid = 0; c.resp_hit = 0; c.resp_rdata = 0;
    fix_en = 0; fix_hit = 0; fix_rdata = 0;
    cmute = 0; cdelay = 3;

    fork
      monitor_loop();
      cache_loop();
    join_none

    #25;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_owner", {31'd0, owner}, 0);
    check("rst_terr", {31'd0, timeout_err}, 0);
    check("rst_creq_v", {31'd0, c.req_valid}, 0);
    check("rst_creq_addr", {12'd0, c.req_addr}, 0);
    check("rst_p0_rv", {31'd0, p0.resp_valid}, 0);
    check("rst_p1_rv", {31'd0, p1.resp_valid}, 0);
    step();
    rst_n = 1'b1;
    step();
    step();

    // single p0 read, hit after 3 cycles
    fix_en = 1; fix_hit = 1; fix_rdata = 32'h11223344; cdelay = 3;
    expect_txn(0, 0, 2'b10, 20'h00040, 32'h0, 0);
    drive_req(0, 0, 2'b10, 20'h00040, 32'h0);
    wait_acc(0, "t1", ta);
    drop_req(0);
    wait_drain("t1", 50);
    check("t1_creq_lat", creq_cyc - ta, 1);
    check("t1_resp_lat", resp_cyc - ta, 5);
    check("t1_owner", {31'd0, owner}, 0);
    fix_en = 0;

    // p1 alone moves the pointer back to p0
    step();
    cdelay = 2;
    expect_txn(1, 1, 2'b10, 20'h0A000, 32'hCAFE0001, 0);
    drive_req(1, 1, 2'b10, 20'h0A000, 32'hCAFE0001);
    wait_acc(1, "p1a", ta);
    drop_req(1);
    wait_drain("p1a", 50);
    check("p1a_owner", {31'd0, owner}, 1);

    // both ports saturated: 0,1,0,1
    step();
    cdelay = 1;
    expect_txn(0, 0, 2'b10, 20'h01000, 32'h0, 0);
    expect_txn(1, 1, 2'b10, 20'h02004, 32'h0BAD0001, 0);
    expect_txn(0, 0, 2'b01, 20'h01010, 32'h0, 0);
    expect_txn(1, 1, 2'b00, 20'h02014, 32'h0BAD0002, 0);
    drive_req(0, 0, 2'b10, 20'h01000, 32'h0);
    drive_req(1, 1, 2'b10, 20'h02004, 32'h0BAD0001);
    fork
      begin
        wait_acc(0, "rr_a0", ta);
        drive_req(0, 0, 2'b01, 20'h01010, 32'h0);
        wait_acc(0, "rr_a1", ta);
        drop_req(0);
      end
      begin
        wait_acc(1, "rr_b0", tb_acc);
        drive_req(1, 1, 2'b00, 20'h02014, 32'h0BAD0002);
        wait_acc(1, "rr_b1", tb_acc);
        drop_req(1);
      end
    join
    wait_drain("rr", 100);

    // p1 alone while pointer is at p0: immediate grant
    step();
    cdelay = 2;
    expect_txn(1, 0, 2'b01, 20'h03333, 32'h0, 0);
    tr = cyc + 1;
    drive_req(1, 0, 2'b01, 20'h03333, 32'h0);
    wait_acc(1, "t3", ta);
    check("t3_lat", ta - tr, 0);
    drop_req(1);
    wait_drain("t3", 50);

    // pointer still at p0: contention grants p0 first
    step();
    expect_txn(0, 0, 2'b10, 20'h04440, 32'h0, 0);
    expect_txn(1, 0, 2'b10, 20'h05550, 32'h0, 0);
    drive_req(0, 0, 2'b10, 20'h04440, 32'h0);
    drive_req(1, 0, 2'b10, 20'h05550, 32'h0);
    fork
      begin wait_acc(0, "rr2_a", ta); drop_req(0); end
      begin wait_acc(1, "rr2_b", tb_acc); drop_req(1); end
    join
    wait_drain("rr2", 50);

    // cache not ready for 10 cycles
    step();
    c.req_ready = 1'b0;
    expect_txn(0, 0, 2'b10, 20'h06660, 32'h0, 0);
    drive_req(0, 0, 2'b10, 20'h06660, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_50);
      #1;
      check("nr_p0_ready", {31'd0, p0.req_ready}, 0);
      check("nr_creq_v", {31'd0, c.req_valid}, 0);
    end
    step();
    c.req_ready = 1'b1;
    tr = cyc + 1;
    wait_acc(0, "nr", ta);
    check("nr_lat", ta - tr, 0);
    drop_req(0);
    wait_drain("nr", 50);

    // response lands exactly in the expiry cycle: real data wins
    step();
    cdelay = TO;
    expect_txn(1, 0, 2'b10, 20'h0B0B0, 32'h0, 0);
    drive_req(1, 0, 2'b10, 20'h0B0B0, 32'h0);
    wait_acc(1, "edge", ta);
    drop_req(1);
    wait_drain("edge", 200);
    check("edge_lat", resp_cyc - ta, 66);
    check("edge_terr", {31'd0, timeout_err}, 0);

    // cache hangs on a p1 write
    step();
    cmute = 1;
    expect_txn(1, 1, 2'b10, 20'h07770, 32'h12345678, 1);
    drive_req(1, 1, 2'b10, 20'h07770, 32'h12345678);
    wait_acc(1, "to", ta);
    drop_req(1);
    check("to_terr_pre", {31'd0, timeout_err}, 0);
    wait_drain("to", 200);
    check("to_lat", resp_cyc - ta, 66);
    @(negedge clk_50);
    #1;
    check("to_terr", {31'd0, timeout_err}, 1);
    check("to_busy", {31'd0, busy}, 0);

    // stray late response while idle is dropped
    step();
    c.resp_valid = 1'b1;
    c.resp_hit = 1'b1;
    c.resp_rdata = 32'h55555555;
    step();
    c.resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50);
      #1;
      check("stray_p0", {31'd0, p0.resp_valid}, 0);
      check("stray_p1", {31'd0, p1.resp_valid}, 0);
    end
    check("stray_hold", p1.resp_rdata, 32'hDEADBEEF);
    check("stray_terr", {31'd0, timeout_err}, 1);

    // reset in the middle of WAIT
    step();
    expect_txn(1, 0, 2'b10, 20'h08880, 32'h0, 0);
    drive_req(1, 0, 2'b10, 20'h08880, 32'h0);
    wait_acc(1, "rw", ta);
    drop_req(1);
    step();
    step();
    check("rw_busy", {31'd0, busy}, 1);
    #5;
    rst_n = 1'b0;
    #1;
    check("rw_busy0", {31'd0, busy}, 0);
    check("rw_owner", {31'd0, owner}, 0);
    check("rw_terr", {31'd0, timeout_err}, 0);
    check("rw_creq_v", {31'd0, c.req_valid}, 0);
    check("rw_creq_addr", {12'd0, c.req_addr}, 0);
    check("rw_p1_rdata", p1.resp_rdata, 0);
    exp_creq.delete();
    exp_resp.delete();
    step();
    step();
    rst_n = 1'b1;
    cmute = 0;
    cdelay = 2;
    step();
    expect_txn(1, 1, 2'b11, 20'h09990, 32'hA5A5A5A5, 0);
    tr = cyc + 1;
    drive_req(1, 1, 2'b11, 20'h09990, 32'hA5A5A5A5);
    wait_acc(1, "post", ta);
    check("post_lat", ta - tr, 0);
    drop_req(1);
    wait_drain("post", 50);
    check("post_owner", {31'd0, owner}, 1);

    step();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
- Two-requester round-robin arbiter sharing the single blocking CPU-side port of the set-associative cache between port 0 (instruction fetch) and port 1 (data access).
- Sits between the requesters and the cache CPU interface: grants one request at a time, forwards it as a single-cycle pulse, routes the cache response back to the owning port.
- Contains a response watchdog so a hung cache/memory path cannot deadlock either requester.

Parameters:
TIMEOUT_CYCLES, 1000, cycles in WAIT without c_resp_valid before the forced error response (range 2..65535)
ERR_DATA, 32'hDEADBEEF, rdata returned on a timed-out request

Ports:
clk_50  in  1  clock; all logic rising-edge
rst_n  in  1  asynchronous, active-low reset
p0_req_valid  in  1  port 0 request; payload held stable until accepted
p0_req_rw  in  1  1 = write, 0 = read
p0_req_size  in  2  access size, passed through
p0_req_addr  in  20  byte address
p0_req_wdata  in  32  write data
p0_req_ready  out  1  accept strobe; request taken when valid and ready in the same cycle
p0_resp_valid  out  1  one-cycle response pulse
p0_resp_hit  out  1  cache hit flag; 0 on timeout
p0_resp_rdata  out  32  read data
p1_req_valid, p1_req_rw, p1_req_size, p1_req_addr, p1_req_wdata, p1_req_ready, p1_resp_valid, p1_resp_hit, p1_resp_rdata: same as port 0
c_req_valid  out  1  one-cycle request pulse to cache
c_req_rw  out  1  registered payload
c_req_size  out  2  registered payload
c_req_addr  out  20  registered payload
c_req_wdata  out  32  registered payload
c_req_ready  in  1  cache can accept
c_resp_valid  in  1  cache response pulse
c_resp_hit  in  1  cache hit
c_resp_rdata  in  32  cache read data
busy  out  1  high in ISSUE or WAIT
owner  out  1  port currently or last granted
timeout_err  out  1  sticky; set on any watchdog expiry

Behaviour:
- Reset (asynchronous, any state): state = IDLE, rr_ptr = 0, owner = 0, timeout_err = 0, watchdog = 0. All c_req_* and p*_resp_* outputs are 0; busy = 0.
- States: IDLE, ISSUE, WAIT.
- Grant selection (combinational, IDLE only):
  - Only one port valid: grant it.
  - Both valid: grant rr_ptr.
  - pX_req_ready = (state==IDLE) & c_req_ready & (grant==X). At most one ready is high per cycle; ready never asserts outside IDLE.
- IDLE -> ISSUE on accept:
  - Latch the granted payload into the c_req_* registers.
  - owner <= grant; rr_ptr <= ~grant.
  - rr_ptr changes only on a grant.
- ISSUE, exactly one cycle: c_req_valid = 1, then -> WAIT with watchdog cleared. c_req_* payload holds its value until the next grant.
- WAIT (and the ISSUE cycle itself) on c_resp_valid:
  - Next cycle: p[owner]_resp_valid = 1 for one cycle, with hit/rdata registered from the cache.
  - -> IDLE.
- Latency:
  - Accept at cycle T, c_req_valid at T+1.
  - Cache response at cycle R gives port response at R+1.
  - Earliest next accept is at R+1 (state is IDLE in that cycle).
- Watchdog: increments every WAIT cycle. At TIMEOUT_CYCLES-1 without a response:
  - p[owner]_resp_valid = 1, resp_hit = 0, resp_rdata = ERR_DATA.
  - timeout_err <= 1; -> IDLE.
  - If c_resp_valid arrives in that same cycle, the real response wins and no error is flagged.
- c_resp_valid received while IDLE (late response after a timeout) is discarded; no port response.
- The non-owner port's resp_valid never asserts. resp_hit/rdata outputs hold their last value when resp_valid = 0.
- c_req_ready low in IDLE: no grant, valids wait indefinitely.
- A requester dropping valid before accept is legal; no grant is recorded.
- Watchdog counter is 16 bits and does not wrap past TIMEOUT_CYCLES.

Test Plan:
- Reset, then p0 read addr 0x00040 with cache responding hit=1 rdata=0x11223344 after 3 cycles -> p0_req_ready pulses at T, c_req_valid at T+1 with addr 0x00040, p0_resp_valid at R+1 with hit=1 rdata=0x11223344; p1_resp_valid stays 0.
- p0 and p1 both valid continuously for 4 transactions -> grant order 0,1,0,1; c_req_addr alternates between the two port addresses; each response is routed to the matching port.
- Only p1 valid while rr_ptr=0 -> p1 granted immediately; rr_ptr becomes 0.
- TIMEOUT_CYCLES=64, cache never responds to a p1 write -> p1_resp_valid 64 cycles after entering WAIT with hit=0 rdata=0xDEADBEEF, timeout_err=1; a later stray c_resp_valid produces no port response.
- c_req_ready held low for 10 cycles with p0 valid -> no p0_req_ready and no c_req_valid; grant on the first cycle ready rises.
- rst_n asserted during WAIT -> all outputs 0 immediately, state IDLE, timeout_err cleared; after release, the next p1-only request is granted normally.
